// File: rtl/matmul_operand_bank.sv
// matmul_operand_bank
//   APB-mapped control, operand and scratchpad bank for the systolic matmul
//   core. It stores the A/B operand rows and the CTRL word. A three-state
//   sequencer (IDLE/RUN/WRITEBACK) starts the array and captures its results
//   into one of SP_NTARGETS scratchpad matrices. Bias mode adds the results to
//   the scratchpad instead of overwriting it.
//
//   Optional build macro: MATMUL_BIAS_SAT_EN. When it is defined, bias-mode
//   additions are signed and saturate to the signed BUS_WIDTH limits, and each
//   saturated element also sets its FLAGS bit. When it is not defined,
//   additions wrap modulo 2^BUS_WIDTH.
//
// Ports
//   clk_i, rst_ni           clock; asynchronous active-low reset
//   psel_i .. pstrb_i       APB request: select, enable, write, address,
//                           write data, and one strobe per DATA_WIDTH lane
//   prdata_o, pready_o,     APB response. There are no wait states.
//   pslverr_o
//   busy_o, start_o         sequencer status; start_o is a level held high
//                           through RUN
//   a_o, b_o                operand rows latched on entry to RUN
//   dim_n/k/m_o             matrix dimensions minus one
//   done_i, result_i,       result handshake from the matmul array
//   flags_i
//   done_o                  one-cycle pulse as WRITEBACK completes
//   dbg_state_o             current sequencer state (0 IDLE, 1 RUN, 2 WRITEBACK)
//
// APB handshake
//   The setup phase is (psel_i & ~penable_i). During setup, the decode error and
//   the read data are registered. The access phase is (psel_i & penable_i).
//   pready_o is high in that phase and prdata_o/pslverr_o are valid. A write
//   that was not flagged as an error commits at the end of the access phase,
//   lane by lane, where pstrb_i is set.
module matmul_operand_bank #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  parameter int SP_NTARGETS = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   psel_i,
  input  logic                                   penable_i,
  input  logic                                   pwrite_i,
  input  logic [ADDR_WIDTH-1:0]                  paddr_i,
  input  logic [BUS_WIDTH-1:0]                   pwdata_i,
  input  logic [MAX_DIM-1:0]                     pstrb_i,
  output logic [BUS_WIDTH-1:0]                   prdata_o,
  output logic                                   pready_o,
  output logic                                   pslverr_o,
  output logic                                   busy_o,
  output logic                                   start_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0]           a_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0]           b_o,
  output logic [$clog2(MAX_DIM)-1:0]             dim_n_o,
  output logic [$clog2(MAX_DIM)-1:0]             dim_k_o,
  output logic [$clog2(MAX_DIM)-1:0]             dim_m_o,
  input  logic                                   done_i,
  input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]   result_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]             flags_i,
  output logic                                   done_o,
  output logic [1:0]                             dbg_state_o
);

  localparam int DW = $clog2(MAX_DIM);
  localparam int IW = 2 * DW;
  localparam int NE = MAX_DIM * MAX_DIM;
  // CTRL bits that exist: start, bias, targets [5:0] and the N/K/M fields.
  localparam logic [BUS_WIDTH-1:0] CTRL_MASK =
    BUS_WIDTH'(32'h3F) | (BUS_WIDTH'((1 << (3 * DW)) - 1) << 8);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_WB = 2'd2} state_t;

  state_t                 r_state;
  logic                   r_busy, r_start, r_done, r_pslverr;
  logic [BUS_WIDTH-1:0]   r_prdata, r_ctrl;
  logic [BUS_WIDTH-1:0]   r_a [MAX_DIM];
  logic [BUS_WIDTH-1:0]   r_b [MAX_DIM];
  logic [BUS_WIDTH-1:0]   r_sp [SP_NTARGETS][NE];
  logic [BUS_WIDTH-1:0]   r_res [NE];
  logic [NE-1:0]          r_flags, r_cap_flags;
  logic [MAX_DIM*BUS_WIDTH-1:0] r_a_o, r_b_o;
  logic [DW-1:0]          r_dim_n, r_dim_k, r_dim_m;

  logic [4:0]             w_off;
  logic [IW-1:0]          w_idx;
  logic [DW-1:0]          w_row;
  logic                   w_row_ok, w_rt_ok, w_lock, w_err, w_wr;
  logic [BUS_WIDTH-1:0]   w_rdata;
  logic [BUS_WIDTH-1:0]   w_acc [NE];
  logic [NE-1:0]          w_sat;
  logic                   w_unused_paddr;

  assign w_off    = paddr_i[4:0];
  assign w_idx    = paddr_i[5 +: IW];
  assign w_row    = w_idx[DW-1:0];
  assign w_row_ok = int'(w_idx) < MAX_DIM;
  assign w_rt_ok  = int'(r_ctrl[5:4]) < SP_NTARGETS;
  // A committed start that the sequencer has not yet picked up locks the
  // registers in the same way RUN does. This closes the one-cycle window
  // before busy_o rises.
  assign w_lock   = r_busy | r_ctrl[0];
  assign w_wr     = psel_i & penable_i & pwrite_i & ~r_pslverr;
  assign w_unused_paddr = &{1'b0, paddr_i};

  // Address decode. The SP element index spans the full idx field, and idx
  // width equals log2(MAX_DIM*MAX_DIM), so the index is always in range.
  always_comb begin
    w_err   = 1'b1;
    w_rdata = '0;
    case (w_off)
      5'd0:  begin w_err = pwrite_i & w_lock;                 w_rdata = r_ctrl;     end
      5'd4:  begin w_err = ~w_row_ok | (pwrite_i & w_lock);   w_rdata = r_a[w_row]; end
      5'd8:  begin w_err = ~w_row_ok | (pwrite_i & w_lock);   w_rdata = r_b[w_row]; end
      5'd12: begin w_err = pwrite_i;                          w_rdata = BUS_WIDTH'(r_flags); end
      5'd16: begin
        w_err = pwrite_i | ~w_rt_ok;
        for (int t = 0; t < SP_NTARGETS; t++)
          if (r_ctrl[5:4] == 2'(t)) w_rdata = r_sp[t][w_idx];
      end
      default: ;
    endcase
  end

  // Next scratchpad value for bias mode, taken from the selected write target.
  always_comb begin
    logic [BUS_WIDTH-1:0] v_old;
`ifdef MATMUL_BIAS_SAT_EN
    logic [BUS_WIDTH:0]   v_sum;
`endif
    for (int e = 0; e < NE; e++) begin
      v_old = '0;
      for (int t = 0; t < SP_NTARGETS; t++)
        if (r_ctrl[3:2] == 2'(t)) v_old = r_sp[t][e];
`ifdef MATMUL_BIAS_SAT_EN
      v_sum    = {v_old[BUS_WIDTH-1], v_old} + {r_res[e][BUS_WIDTH-1], r_res[e]};
      // The two top bits of the sign-extended sum differ only on signed overflow.
      w_sat[e] = r_ctrl[1] & (v_sum[BUS_WIDTH] ^ v_sum[BUS_WIDTH-1]);
      if (v_sum[BUS_WIDTH] ^ v_sum[BUS_WIDTH-1])
        w_acc[e] = v_sum[BUS_WIDTH] ? {1'b1, {(BUS_WIDTH-1){1'b0}}}
                                    : {1'b0, {(BUS_WIDTH-1){1'b1}}};
      else
        w_acc[e] = v_sum[BUS_WIDTH-1:0];
`else
      w_sat[e] = 1'b0;
      w_acc[e] = v_old + r_res[e];
`endif
    end
  end

  // APB setup-phase capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else if (psel_i & ~penable_i) begin
      r_prdata  <= w_err ? '0 : w_rdata;
      r_pslverr <= w_err;
    end
  end

  // Register storage: APB writes, plus the WRITEBACK update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ctrl  <= '0;
      r_flags <= '0;
      for (int r = 0; r < MAX_DIM; r++) begin
        r_a[r] <= '0;
        r_b[r] <= '0;
      end
      for (int t = 0; t < SP_NTARGETS; t++)
        for (int e = 0; e < NE; e++) r_sp[t][e] <= '0;
    end else begin
      if (w_wr) begin
        for (int l = 0; l < MAX_DIM; l++) begin
          if (pstrb_i[l]) begin
            case (w_off)
              5'd0: r_ctrl[l*DATA_WIDTH +: DATA_WIDTH] <=
                      pwdata_i[l*DATA_WIDTH +: DATA_WIDTH] & CTRL_MASK[l*DATA_WIDTH +: DATA_WIDTH];
              5'd4: r_a[w_row][l*DATA_WIDTH +: DATA_WIDTH] <= pwdata_i[l*DATA_WIDTH +: DATA_WIDTH];
              5'd8: r_b[w_row][l*DATA_WIDTH +: DATA_WIDTH] <= pwdata_i[l*DATA_WIDTH +: DATA_WIDTH];
              default: ;
            endcase
          end
        end
      end
      if (r_state == S_WB) begin
        r_ctrl[0] <= 1'b0;
        r_flags   <= r_cap_flags | w_sat;
        for (int t = 0; t < SP_NTARGETS; t++)
          if (r_ctrl[3:2] == 2'(t))
            for (int e = 0; e < NE; e++)
              r_sp[t][e] <= r_ctrl[1] ? w_acc[e] : r_res[e];
      end
    end
  end

  // Sequencer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_a_o       <= '0;
      r_b_o       <= '0;
      r_dim_n     <= '0;
      r_dim_k     <= '0;
      r_dim_m     <= '0;
      r_cap_flags <= '0;
      for (int e = 0; e < NE; e++) r_res[e] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (r_ctrl[0]) begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
          r_start <= 1'b1;
          r_dim_n <= r_ctrl[8 +: DW];
          r_dim_k <= r_ctrl[8 + DW +: DW];
          r_dim_m <= r_ctrl[8 + 2*DW +: DW];
          for (int r = 0; r < MAX_DIM; r++) begin
            r_a_o[r*BUS_WIDTH +: BUS_WIDTH] <= (DW'(r) <= r_ctrl[8 +: DW])        ? r_a[r] : '0;
            r_b_o[r*BUS_WIDTH +: BUS_WIDTH] <= (DW'(r) <= r_ctrl[8 + 2*DW +: DW]) ? r_b[r] : '0;
          end
        end
        S_RUN: if (done_i) begin
          r_state     <= S_WB;
          r_start     <= 1'b0;
          r_a_o       <= '0;
          r_b_o       <= '0;
          r_cap_flags <= flags_i;
          for (int e = 0; e < NE; e++) r_res[e] <= result_i[e*BUS_WIDTH +: BUS_WIDTH];
        end
        S_WB: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign prdata_o    = r_prdata;
  assign pslverr_o   = r_pslverr;
  assign pready_o    = psel_i & penable_i;
  assign busy_o      = r_busy;
  assign start_o     = r_start;
  assign done_o      = r_done;
  assign a_o         = r_a_o;
  assign b_o         = r_b_o;
  assign dim_n_o     = r_dim_n;
  assign dim_k_o     = r_dim_k;
  assign dim_m_o     = r_dim_m;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_matmul_operand_bank.sv
module tb_matmul_operand_bank;
  localparam int BW = 32;
  localparam int MD = 4;
  localparam int NE = MD * MD;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0]       paddr = '0;
  logic [BW-1:0]     pwdata = '0;
  logic [MD-1:0]     pstrb = '0;
  logic [BW-1:0]     prdata;
  logic              pready, pslverr, busy, start, done_o;
  logic [MD*BW-1:0]  a_o, b_o;
  logic [1:0]        dim_n, dim_k, dim_m, dbg_state;
  logic              done_i = 1'b0;
  logic [NE*BW-1:0]  result_i = '0;
  logic [NE-1:0]     flags_i = '0;

  int checks = 0;
  int failures = 0;
  logic [BW-1:0] exp_q[$];

  matmul_operand_bank dut (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .busy_o(busy), .start_o(start), .a_o(a_o), .b_o(b_o),
    .dim_n_o(dim_n), .dim_k_o(dim_k), .dim_m_o(dim_m),
    .done_i(done_i), .result_i(result_i), .flags_i(flags_i),
    .done_o(done_o), .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ad(input int off, input int idx);
    return 16'(off + (idx << 5));
  endfunction

  // One APB transfer: setup, access, then idle.
  task automatic apb(input logic w, input logic [15:0] addr, input logic [BW-1:0] wdata,
                     input logic [MD-1:0] strb, input logic exp_err, input logic chk_rd,
                     input logic [BW-1:0] exp_rd, input string tag);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = addr; pwdata = wdata; pstrb = strb;
    if (chk_rd) exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk({tag, "/pready"}, BW'(pready), 1);
    chk({tag, "/pslverr"}, BW'(pslverr), BW'(exp_err));
    if (chk_rd) chk(tag, prdata, exp_q.pop_front());
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [BW-1:0] d, input logic [MD-1:0] s,
                    input logic err, input string tag);
    apb(1'b1, addr, d, s, err, 1'b0, '0, tag);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [BW-1:0] e, input string tag);
    apb(1'b0, addr, '0, '0, 1'b0, 1'b1, e, tag);
  endtask

  task automatic rd_err(input logic [15:0] addr, input string tag);
    apb(1'b0, addr, '0, '0, 1'b1, 1'b0, '0, tag);
  endtask

  // Write CTRL with start set, then wait (bounded) for busy.
  task automatic start_mm(input logic [BW-1:0] ctrl, input string tag);
    wr(ad(0, 0), ctrl, '1, 1'b0, {tag, "/ctrl"});
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    chk({tag, "/busy up"}, BW'(busy), 1);
    chk({tag, "/start_o"}, BW'(start), 1);
  endtask

  // Present a result with a single done pulse. Then scramble the inputs so
  // that only values captured in the done cycle can reach the scratchpad.
  task automatic finish_mm(input logic [NE*BW-1:0] res, input logic [NE-1:0] flg, input string tag);
    int n;
    @(posedge clk); #1;
    done_i = 1'b1; result_i = res; flags_i = flg;
    @(posedge clk); #1;
    done_i = 1'b0; result_i = {NE{32'hDEADBEEF}}; flags_i = '1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_o) n++;
    end
    chk({tag, "/done pulses"}, BW'(n), 1);
    chk({tag, "/busy down"}, BW'(busy), 0);
    chk({tag, "/start down"}, BW'(start), 0);
    chk({tag, "/a_o cleared"}, BW'(|a_o), 0);
  endtask

  initial begin
    int am [2][2];
    int bm [2][2];
    int c;
    int n;
    logic [NE*BW-1:0] res;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst busy", BW'(busy), 0);
    chk("rst start", BW'(start), 0);
    chk("rst done", BW'(done_o), 0);
    chk("rst pslverr", BW'(pslverr), 0);
    chk("rst prdata", prdata, 0);
    chk("rst a_o", BW'(|a_o), 0);
    chk("rst state", BW'(dbg_state), 0);
    rst_n = 1'b1;
    rd(ad(0, 0), 0, "rst ctrl");
    rd(ad(16, 0), 0, "rst sp");

    // lane strobes
    wr(ad(4, 1), 32'hAAAAAAAA, 4'hF, 1'b0, "a1 fill");
    wr(ad(4, 1), 32'h04030201, 4'b0101, 1'b0, "a1 strobe");
    rd(ad(4, 1), 32'hAA03AA01, "a1 readback");

    // plain run, 2x2
    am = '{'{1, 2}, '{3, 4}};
    bm = '{'{5, 6}, '{7, 8}};
    for (int r = 0; r < 2; r++) begin
      wr(ad(4, r), {16'h0, 8'(am[r][1]), 8'(am[r][0])}, '1, 1'b0, "a row");
      wr(ad(8, r), {16'h0, 8'(bm[r][1]), 8'(bm[r][0])}, '1, 1'b0, "b row");
    end
    wr(ad(4, 2), 32'h11111111, '1, 1'b0, "a row2");
    start_mm(32'h1501, "plain");
    chk("plain a_o r0", a_o[0 +: BW], 32'h0201);
    chk("plain a_o r1", a_o[BW +: BW], 32'h0403);
    chk("plain a_o r2 beyond N", a_o[2*BW +: BW], 0);
    chk("plain b_o r1", b_o[BW +: BW], 32'h0807);
    chk("plain dims", BW'({dim_n, dim_k, dim_m}), 32'h15);
    wr(ad(4, 0), 32'hDEADBEEF, '1, 1'b1, "busy a write");
    wr(ad(0, 0), 32'h0, '1, 1'b1, "busy ctrl write");
    rd(ad(4, 0), 32'h0201, "busy a read");
    res = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        c = 0;
        for (int k = 0; k < 2; k++) c += am[i][k] * bm[k][j];
        res[(i*MD + j)*BW +: BW] = BW'(c);
      end
    finish_mm(res, 16'h0003, "plain");
    rd(ad(16, 0), 19, "sp0 e0");
    rd(ad(16, 1), 22, "sp0 e1");
    rd(ad(16, MD), 43, "sp0 e4");
    rd(ad(16, MD + 1), 50, "sp0 e5");
    rd(ad(0, 0), 32'h1500, "ctrl start cleared");
    rd(ad(12, 0), 32'h3, "flags");

    // done in IDLE is ignored
    @(posedge clk); #1;
    done_i = 1'b1; result_i = {NE{32'h77777777}}; flags_i = '1;
    @(posedge clk); #1;
    done_i = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_o) n++;
    end
    chk("spurious done_o", BW'(n), 0);
    rd(ad(16, 0), 19, "spurious sp");
    rd(ad(12, 0), 32'h3, "spurious flags");

    // target 1 preload, then a bias run
    start_mm(32'h1505, "preload");
    res = '0;
    res[0 +: BW] = 100;
    res[BW +: BW] = 32'h7FFFFFFF;
    finish_mm(res, '0, "preload");
    rd(ad(12, 0), 0, "preload flags");
    wr(ad(0, 0), 32'h1510, '1, 1'b0, "rt=1");
    rd(ad(16, 0), 100, "sp1 e0 preload");
    start_mm(32'h1507, "bias");
    res = '0;
    res[0 +: BW] = 5;
    res[BW +: BW] = 1;
    finish_mm(res, '0, "bias");
    wr(ad(0, 0), 32'h1510, '1, 1'b0, "rt=1 again");
    rd(ad(16, 0), 105, "sp1 bias e0");
`ifdef MATMUL_BIAS_SAT_EN
    rd(ad(16, 1), 32'h7FFFFFFF, "sp1 bias sat");
    rd(ad(12, 0), 32'h2, "bias sat flag");
`else
    rd(ad(16, 1), 32'h80000000, "sp1 bias wrap");
    rd(ad(12, 0), 32'h0, "bias flags");
`endif
    wr(ad(0, 0), 32'h1500, '1, 1'b0, "rt=0");
    rd(ad(16, 0), 19, "sp0 untouched");

    // protection and decode errors
    wr(ad(20, 0), 32'h1, '1, 1'b1, "wr off20");
    wr(ad(16, 0), 32'h1, '1, 1'b1, "wr sp");
    wr(ad(12, 0), 32'h1, '1, 1'b1, "wr flags");
    rd(ad(16, 0), 19, "sp after wr");
    wr(ad(0, 0), 32'h1530, '1, 1'b0, "rt=3");
    rd_err(ad(16, 0), "rd target3");
    rd_err(ad(4, 5), "rd a idx5");
    rd(ad(4, 0), 32'h0201, "a0 unchanged");

    // reset in the middle of RUN
    start_mm(32'h1501, "rstrun");
    rst_n = 1'b0;
    #1;
    chk("rstrun busy", BW'(busy), 0);
    chk("rstrun start", BW'(start), 0);
    chk("rstrun state", BW'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(ad(0, 0), 0, "rstrun ctrl");
    rd(ad(12, 0), 0, "rstrun flags");
    rd(ad(16, 0), 0, "rstrun sp0");
    wr(ad(0, 0), 32'h10, '1, 1'b0, "rstrun rt=1");
    rd(ad(16, 0), 0, "rstrun sp1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
